// File: rtl/cmd_line_packer.sv
// Assembles a byte-serial ASCII line into a right-justified packed word.
// Over-long lines are dropped whole and flagged instead of truncated.
module cmd_line_packer #(
  parameter int NUM_CHARS  = 7,
  parameter int A_NUM_BITS = NUM_CHARS * 8,
  parameter int U_NUM_BITS = 4,
  parameter int CNT_BITS   = $clog2(NUM_CHARS + 1)
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_byte_vld,
  input  logic [7:0]            i_byte,
  input  logic [U_NUM_BITS-1:0] i_u,
  output logic [A_NUM_BITS-1:0] o_a,
  output logic [U_NUM_BITS-1:0] o_u,
  output logic                  o_rdy,
  output logic                  o_err_ovf,
  output logic [CNT_BITS-1:0]   o_len
);

  typedef enum logic {
    COLLECT,
    DISCARD
  } state_e;

  localparam logic [CNT_BITS-1:0] MAX_CNT = CNT_BITS'(NUM_CHARS);

  state_e                  state_q;
  logic [A_NUM_BITS-1:0]   line_q;
  logic [CNT_BITS-1:0]     cnt_q;

  logic is_prt;
  logic is_bs;
  logic is_term;

  assign is_prt  = (i_byte >= 8'h20) && (i_byte <= 8'h7E);
  assign is_bs   = (i_byte == 8'h08);
  assign is_term = (i_byte == 8'h0D) || (i_byte == 8'h0A);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q   <= COLLECT;
      line_q    <= '0;
      cnt_q     <= '0;
      o_a       <= '0;
      o_u       <= '0;
      o_len     <= '0;
      o_rdy     <= 1'b0;
      o_err_ovf <= 1'b0;
    end else begin
      o_rdy     <= 1'b0;
      o_err_ovf <= 1'b0;
      if (i_byte_vld) begin
        unique case (1'b1)
          is_prt: begin
            if (state_q == COLLECT) begin
              if (cnt_q < MAX_CNT) begin
                line_q <= {line_q[A_NUM_BITS-9:0], i_byte};
                cnt_q  <= cnt_q + 1'b1;
              end else begin
                state_q <= DISCARD;
              end
            end
          end
          is_bs: begin
            if (state_q == COLLECT && cnt_q != '0) begin
              line_q <= line_q >> 8;
              cnt_q  <= cnt_q - 1'b1;
            end
          end
          is_term: begin
            // A dropped line only reports; the last good word stays on o_a.
            if (state_q == DISCARD) begin
              o_err_ovf <= 1'b1;
              line_q    <= '0;
              cnt_q     <= '0;
              state_q   <= COLLECT;
            end else if (cnt_q != '0) begin
              o_a    <= line_q;
              o_u    <= i_u;
              o_len  <= cnt_q;
              o_rdy  <= 1'b1;
              line_q <= '0;
              cnt_q  <= '0;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: doc/cmd_line_packer.md
# cmd_line_packer

Upstream front end for the shop controller. Receives a byte-serial ASCII stream (one character per valid cycle) from a terminal/UART receiver and assembles each line into the right-justified packed word the shop controller expects on its `i_a` input. When a terminator arrives, it presents the word with the captured user field and fires a one-cycle ready pulse, which drives the controller's `i_rdy`. Over-long lines are dropped and flagged; they are never truncated.

## Interface
- `NUM_CHARS`, default 7: maximum characters per line; must fit the longest command key ("AddItem").
- `A_NUM_BITS`, default `NUM_CHARS*8`: packed word width.
- `U_NUM_BITS`, default 4: user-field width.
- `CNT_BITS`, default `$clog2(NUM_CHARS+1)`: character counter width.

Ports:
- `i_clk`, in, 1: the single clock; everything is rising-edge.
- `i_reset`, in, 1: asynchronous, active-high reset.
- `i_byte_vld`, in, 1: `i_byte` is valid this cycle. There is no backpressure; the block accepts one byte per cycle.
- `i_byte`, in, 8: ASCII character.
- `i_u`, in, `U_NUM_BITS`: user field, sampled on the terminator cycle.
- `o_a`, out, `A_NUM_BITS`: packed line that drives the controller's `i_a`.
- `o_u`, out, `U_NUM_BITS`: captured user field that drives the controller's `i_u`.
- `o_rdy`, out, 1: one-cycle pulse marking a new `o_a`/`o_u`. Drives the controller's `i_rdy`.
- `o_err_ovf`, out, 1: one-cycle pulse when an over-long line is dropped.
- `o_len`, out, `CNT_BITS`: character count of the last emitted line.

## Operation
- **Internal state:** line buffer `buf` (`A_NUM_BITS`), counter `cnt` (`CNT_BITS`), and a 2-state FSM with states COLLECT and DISCARD.
- **Packing rule:** the buffer matches Verilog string-literal encoding.
  - Accepting a character does `buf <= {buf[A_NUM_BITS-9:0], i_byte}`.
  - The last character sits in byte 0. Unused upper bytes are 0x00.
  - Example: "Adm" packs to `...00_41_64_6D`.
- **Byte classes** (only when `i_byte_vld`=1):
  - Printable, 0x20–0x7E:
    - COLLECT with `cnt < NUM_CHARS`: shift in, `cnt++`.
    - COLLECT with `cnt == NUM_CHARS`: go to DISCARD; `buf` and `cnt` are unchanged.
    - DISCARD: ignored.
  - Backspace, 0x08:
    - COLLECT with `cnt > 0`: `buf <= buf >> 8`, `cnt--`.
    - COLLECT with `cnt == 0`: no-op.
    - DISCARD: ignored.
  - Terminator, 0x0D or 0x0A:
    - COLLECT with `cnt > 0`: emit, i.e. `o_a <= buf`, `o_u <= i_u`, `o_len <= cnt`, `o_rdy <= 1`. Then clear `buf` and `cnt`.
    - COLLECT with `cnt == 0`: ignored. This covers empty lines and the LF of a CR/LF pair. No pulse.
    - DISCARD: `o_err_ovf <= 1`, clear `buf` and `cnt`, go to COLLECT. `o_a`, `o_u` and `o_len` are unchanged.
  - Any other byte: ignored.
- `o_a`, `o_u` and `o_len` hold their value until the next emit.
- **Reset:** asynchronous. Sets `buf`, `cnt`, `o_a`, `o_u`, `o_len`, `o_rdy` and `o_err_ovf` to 0, and the FSM to COLLECT. Reset mid-line drops the partial line with no pulse.

## Timing
- **Latency:** terminator sampled at edge k → `o_a`/`o_u`/`o_rdy` valid after edge k. `o_rdy` is high for exactly one cycle and drops after edge k+1.
- All outputs are registered. There is no combinational path from inputs to outputs.
- `o_rdy` and `o_err_ovf` are never high in the same cycle.
- A byte valid in the cycle `o_rdy` is high is accepted into the already-cleared buffer. Back-to-back lines work with zero idle cycles, e.g. "Buy\rBuy\r" yields two pulses 4 cycles apart.
- A line of exactly `NUM_CHARS` characters is legal. Only the (`NUM_CHARS`+1)th printable character triggers DISCARD.
- Backspace applied after DISCARD has been entered does not recover the line.

## Test plan
- **Basic emit:** reset 1 cycle, then "Login\r" at 1 byte/cycle, with `i_u`=4'h3 on the CR cycle.
  - `o_a` = 56'h00_00_4C_6F_67_69_6E.
  - `o_u` = 3, `o_len` = 5.
  - `o_rdy` high exactly 1 cycle, after the CR edge.
- **Full-width line:** "AddItem\r" → `o_a` = "AddItem" (56'h41_64_64_49_74_65_6D), `o_len` = 7, one `o_rdy`.
- **Overflow:** "AddItemX\r" → one `o_err_ovf` pulse, no `o_rdy`, `o_a` unchanged. A following "Buy\r" emits "Buy" (`o_a` = 56'h..._42_75_79).
- **Backspace:** "Ad", 0x08, "dm\r" → `o_a` = "Adm" (24'h41_64_6D in the low bytes), `o_len` = 3. A leading 0x08 on an empty buffer has no effect.
- **Empty lines and CR/LF:** "\r\n", then "Us1\r\n" → exactly one `o_rdy`, with `o_a` = "Us1". Gaps in `i_byte_vld` between characters do not change the result.
- **Reset mid-line:** "Logo", then assert `i_reset` asynchronously between edges.
  - Outputs go to 0 immediately.
  - After release, "Ps1\r" emits "Ps1" with no residue of "Logo".
